// File: rtl/cmp_pkg.sv
// Shared definitions for the magnitude comparators: scan FSM state encoding,
// bit positions inside the 6-bit relational flag vector, and the helper that
// builds that vector from a {lt,gt} decision.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int EQ  = 0;
    localparam int NEQ = 1;
    localparam int LT  = 2;
    localparam int GT  = 3;
    localparam int LE  = 4;
    localparam int GE  = 5;

    // {lt,gt} = 2'b10 -> less, 2'b01 -> greater, anything else -> equal.
    function automatic logic [5:0] build_flags(input logic [1:0] lt_gt);
        logic [5:0] flags;
        flags = '0;
        case (lt_gt)
            2'b10: begin
                flags[LT]  = 1'b1;
                flags[LE]  = 1'b1;
                flags[NEQ] = 1'b1;
            end
            2'b01: begin
                flags[GT]  = 1'b1;
                flags[GE]  = 1'b1;
                flags[NEQ] = 1'b1;
            end
            default: begin
                flags[EQ] = 1'b1;
                flags[LE] = 1'b1;
                flags[GE] = 1'b1;
            end
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/cmp_flag_encode.sv
// Combinational flag encoder shared by the 2-bit and sequential comparators
// so both present an identical eq/neq/lt/gt/le/ge layout.
module cmp_flag_encode
    import cmp_pkg::*;
(
    input  logic       lt,
    input  logic       gt,
    input  logic       eq,
    output logic [5:0] y
);

    // eq takes priority so a contradictory lt/gt pair can never leak out
    always_comb begin
        y = build_flags({lt, gt});
        if (eq) begin
            y = build_flags(2'b00);
        end
    end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: captures A/B on start, scans MSB-first one
// bit per clock, stops at the first differing bit and reports six relational
// flags with a one-cycle done pulse. Optional two's-complement ordering.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [5:0]       Y
);

    localparam int              IDX_W   = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [5:0]       y_reg;

    logic       a_bit;
    logic       b_bit;
    logic       bits_differ;
    logic       at_msb;
    logic       a_greater;
    logic       lt_now;
    logic       gt_now;
    logic       eq_now;
    logic       scan_last;
    logic [5:0] flags_next;

    // Per-bit decision for the bit currently under the scan pointer.
    // In signed mode the sign bit has inverted weight: a set MSB means negative.
    always_comb begin
        a_bit       = a_reg[idx_reg];
        b_bit       = b_reg[idx_reg];
        bits_differ = a_bit ^ b_bit;
        at_msb      = (idx_reg == MSB_IDX);
        a_greater   = ((SIGNED != 0) && at_msb) ? ~a_bit : a_bit;
        gt_now      = bits_differ & a_greater;
        lt_now      = bits_differ & ~a_greater;
        eq_now      = ~bits_differ;
        scan_last   = bits_differ | (idx_reg == '0);
    end

    cmp_flag_encode u_flag_encode (
        .lt (lt_now),
        .gt (gt_now),
        .eq (eq_now),
        .y  (flags_next)
    );

    // Scan FSM with registered busy/done/Y; DONE can accept a new request
    // directly so back-to-back compares need no idle cycle in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            y_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        idx_reg   <= MSB_IDX;
                        y_reg     <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SCAN;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                SCAN: begin
                    if (scan_last) begin
                        y_reg     <= flags_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign Y    = y_reg;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: an unsigned and a signed instance share
// the same stimulus; expected flags/latency are queued at drive time and
// popped by a monitor when done pulses.
module tb_seq_magnitude_comparator;

    localparam logic [5:0] Y_EQ = 6'b110001;
    localparam logic [5:0] Y_GT = 6'b101010;
    localparam logic [5:0] Y_LT = 6'b010110;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic       busy_u, done_u, busy_s, done_s;
    logic [5:0] y_u, y_s;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] yu;
        logic [5:0] ys;
        int         lat;
        int         acc;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] yu;
        logic [5:0] ys;
        int         lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    seq_magnitude_comparator #(.WIDTH(8), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in),
        .busy(busy_u), .done(done_u), .Y(y_u)
    );

    seq_magnitude_comparator #(.WIDTH(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in),
        .busy(busy_s), .done(done_s), .Y(y_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [5:0] model_y(input logic [7:0] a, input logic [7:0] b, input bit sgn);
        if (a == b) return Y_EQ;
        if (sgn ? ($signed(a) < $signed(b)) : (a < b)) return Y_LT;
        return Y_GT;
    endfunction

    function automatic int model_lat(input logic [7:0] a, input logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            if (a[k] != b[k]) return 2 + (7 - k);
        end
        return 9;
    endfunction

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [5:0] yu,
                            input logic [5:0] ys, input int lat, input int acc);
        exp_t e;
        e.a = a; e.b = b; e.yu = yu; e.ys = ys; e.lat = lat; e.acc = acc;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done_u || done_s) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: done_u=%0b done_s=%0b with nothing outstanding (cycle %0d)",
                         done_u, done_s, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn a=%02h b=%02h Y_u=%06b Y_s=%06b latency=%0d", e.a, e.b, y_u, y_s, cyc - e.acc + 1);
                chk("y_unsigned", 32'(y_u), 32'(e.yu));
                chk("y_signed", 32'(y_s), 32'(e.ys));
                chk("done_pair", 32'(done_s), 32'(done_u));
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                chk("busy_at_done", 32'(busy_u), 32'd0);
            end
        end
    end

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results still outstanding after %0d cycles", sb.size(), bound);
            sb.delete();
        end
    endtask

    task automatic run_one(input logic [7:0] a, input logic [7:0] b, input logic [5:0] yu,
                           input logic [5:0] ys, input int lat);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        push_exp(a, b, yu, ys, lat, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        drain(40);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pa[5];
        logic [7:0] pb[5];
        int acc;
        int acc_next;

        vecs[0] = '{8'h5A, 8'h5A, Y_EQ, Y_EQ, 9};
        vecs[1] = '{8'h80, 8'h7F, Y_GT, Y_LT, 2};
        vecs[2] = '{8'h10, 8'h11, Y_LT, Y_LT, 9};
        vecs[3] = '{8'hFF, 8'hFE, Y_GT, Y_GT, 9};
        vecs[4] = '{8'h00, 8'h00, Y_EQ, Y_EQ, 9};
        vecs[5] = '{8'h7F, 8'h80, Y_LT, Y_GT, 2};
        vecs[6] = '{8'h40, 8'h20, Y_GT, Y_GT, 3};
        vecs[7] = '{8'hC0, 8'h80, Y_GT, Y_GT, 3};
        vecs[8] = '{8'h01, 8'h02, Y_LT, Y_LT, 8};
        vecs[9] = '{8'h80, 8'h00, Y_GT, Y_LT, 2};

        // reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy_u | busy_s), 32'd0);
        chk("reset_done", 32'(done_u | done_s), 32'd0);
        chk("reset_y_u", 32'(y_u), 32'd0);
        chk("reset_y_s", 32'(y_s), 32'd0);

        // table-driven vectors
        for (int i = 0; i < 10; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].yu, vecs[i].ys, vecs[i].lat);
        end

        // start during SCAN is ignored and pin changes have no effect
        @(negedge clk);
        a_in = 8'h01; b_in = 8'h02; start = 1'b1;
        push_exp(8'h01, 8'h02, Y_LT, Y_LT, 8, cyc + 1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_scan", 32'(busy_u), 32'd1);
        chk("y_cleared_on_accept", 32'(y_u), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
            @(negedge clk);
            start = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom);
        end
        drain(40);
        repeat (2) @(negedge clk);
        chk("y_hold_u", 32'(y_u), 32'(Y_LT));
        chk("y_hold_s", 32'(y_s), 32'(Y_LT));
        chk("idle_busy", 32'(busy_u), 32'd0);

        // reset mid-SCAN discards the compare
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midscan_rst_busy", 32'(busy_u | busy_s), 32'd0);
        chk("midscan_rst_done", 32'(done_u | done_s), 32'd0);
        chk("midscan_rst_y", 32'({y_u, y_s}), 32'd0);
        repeat (12) @(negedge clk);
        chk("no_busy_after_rst", 32'(busy_u), 32'd0);
        run_one(8'h00, 8'h00, Y_EQ, Y_EQ, 9);

        // rst and start on the same edge: rst wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a_in = 8'h80; b_in = 8'h7F;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_wins_busy", 32'(busy_u), 32'd0);
        chk("rst_wins_y", 32'(y_u), 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_wins_still_idle", 32'(busy_u), 32'd0);

        // back-to-back compares with start held high
        pa[0] = 8'h80; pb[0] = 8'h7F;
        pa[1] = 8'h5A; pb[1] = 8'h5A;
        pa[2] = 8'h40; pb[2] = 8'h20;
        pa[3] = 8'h01; pb[3] = 8'h02;
        pa[4] = 8'hFF; pb[4] = 8'hFE;
        @(negedge clk);
        a_in = pa[0]; b_in = pb[0]; start = 1'b1;
        acc = cyc + 1;
        push_exp(pa[0], pb[0], model_y(pa[0], pb[0], 1'b0), model_y(pa[0], pb[0], 1'b1),
                 model_lat(pa[0], pb[0]), acc);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            a_in = pa[i]; b_in = pb[i];
            acc_next = acc + model_lat(pa[i-1], pb[i-1]);
            push_exp(pa[i], pb[i], model_y(pa[i], pb[i], 1'b0), model_y(pa[i], pb[i], 1'b1),
                     model_lat(pa[i], pb[i]), acc_next);
            while (cyc + 1 != acc_next) @(negedge clk);
            acc = acc_next;
        end
        @(negedge clk);
        start = 1'b0;
        drain(60);

        // random pairs against the reference model
        for (int i = 0; i < 12; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = (i % 3 == 0) ? ra ^ (8'h01 << (i % 8)) : 8'($urandom);
            run_one(ra, rb, model_y(ra, rb, 1'b0), model_y(ra, rb, 1'b1), model_lat(ra, rb));
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
